adc_sample_sequencer: RTL and testbench
=======================================

// Module: adc_sample_sequencer
// PURPOSE
//  Periodic acquisition controller for the VU-meter front end.
//  - Divides clk_in into a sample-rate tick.
//  - On each tick, runs one frame: a start/done handshake with the ADC interface for channels 0..NUM_CH-1 in order.
//  - Presents each converted sample downstream as a one-cycle valid strobe.
//  - Flags dropped ticks (overrun) and stalled conversions (timeout).
// PARAMETERS
//  IN_FREQ      100000000  clk_in frequency, Hz
//  SAMPLE_FREQ  10000      frame rate, Hz; TICK_DIV = IN_FREQ/SAMPLE_FREQ (integer division), TICK_DIV >= 2
//  CNT_W        16         tick counter width; TICK_DIV <= 2**CNT_W required
//  NUM_CH       2          channels per frame, 1..2**CH_W
//  CH_W         1          channel index width
//  DATA_W       12         ADC sample width
//  TIMEOUT_CYC  1024       max cycles spent in WAIT per conversion, >= 2
// PORTS
//  clk_in       in   1       system clock
//  reset        in   1       asynchronous, active-high reset
//  enable       in   1       1 = tick counter runs; 0 = counter holds, no new frames
//  adc_start    out  1       one-cycle conversion request
//  adc_ch       out  CH_W    channel for current conversion, stable from START until the next START
//  adc_done     in   1       one-cycle conversion complete, qualifies adc_data
//  adc_data     in   DATA_W  conversion result
//  sample_valid out  1       one-cycle strobe, sample_ch/sample_data valid
//  sample_ch    out  CH_W    channel of presented sample (held until next strobe)
//  sample_data  out  DATA_W  captured sample (held until next strobe)
//  busy         out  1       1 whenever state != IDLE
//  overrun      out  1       one-cycle pulse: a tick arrived while a frame was in progress
//  timeout_err  out  1       one-cycle pulse: a conversion exceeded TIMEOUT_CYC
// BEHAVIOUR
//  Reset
//   - All outputs 0, state IDLE, all counters 0, channel index 0.
//   - Asserted mid-frame: aborts the frame immediately; adc_start drops asynchronously; no further pulses.
//  Tick counter
//   - When enable=1: increments each cycle; on value TICK_DIV-1, tick=1 (combinational) for that cycle and the counter wraps to 0.
//   - When enable=0: holds its value; tick=0.
//  FSM states: IDLE, START, WAIT, STORE; outputs are Moore-decoded from registered state.
//   - IDLE:  tick -> START, ch=0.
//   - START: adc_start=1, adc_ch=ch; clears the wait counter -> WAIT. adc_done in this cycle is ignored.
//   - WAIT:  wait counter increments each cycle.
//       - adc_done=1: capture adc_data into sample_data and ch into sample_ch -> STORE.
//       - Else if wait counter == TIMEOUT_CYC-1: timeout_err=1 the next cycle; frame aborted -> IDLE.
//       - adc_done in the same cycle as the timeout condition: done wins.
//   - STORE: sample_valid=1.
//       - ch==NUM_CH-1 -> IDLE.
//       - Else ch+1 -> START.
//  Latency
//   - Tick in cycle N -> adc_start high in N+1.
//   - adc_done in cycle M -> sample_valid in M+1 -> next adc_start in M+2.
//  Overrun
//   - A tick while state != IDLE is dropped; overrun=1 the following cycle.
//   - The frame in progress continues unaffected.
//   - A tick in the same cycle as the STORE->IDLE transition also counts as overrun (the frame is not restarted).
//  enable falling mid-frame: the current frame completes normally; no new ticks until enable returns.
// TESTING (bench: IN_FREQ=1000, SAMPLE_FREQ=10 -> TICK_DIV=100, NUM_CH=2, TIMEOUT_CYC=16)
//  1. Reset, then enable=1; ADC model answers done 3 cycles after start with data 0x123 (ch0) and 0xABC (ch1).
//     -> First adc_start at cycle 100 after enable, adc_ch=0.
//     -> sample_valid with ch0/0x123, then ch1/0xABC.
//     -> Frames repeat every 100 cycles.
//  2. ADC never asserts done.
//     -> timeout_err pulses 17 cycles after adc_start; busy=0 next cycle.
//     -> No sample_valid; next tick starts ch0 again.
//  3. ADC done latency 60 cycles, TIMEOUT_CYC=128.
//     -> Tick at frame+100 arrives during ch1 WAIT: overrun pulses once.
//     -> Both samples still delivered.
//     -> Next frame starts on the following tick.
//  4. adc_done asserted in START and at the timeout cycle.
//     -> START-cycle done ignored; timeout-cycle done captured, no timeout_err.
//  5. reset asserted during WAIT of ch1.
//     -> All outputs 0 immediately; after release, first adc_start 100 cycles after enable, ch0.
//  6. enable dropped mid-frame for 500 cycles.
//     -> Current frame finishes; no adc_start while low.
//     -> Counter resumes from its held value.

Source files
------------

// File: rtl/adc_sample_sequencer.sv
// Periodic ADC acquisition controller: divides clk_in into a frame tick, then walks
// channels 0..NUM_CH-1 through a start/done handshake and strobes each sample downstream.
module adc_sample_sequencer #(
    parameter int IN_FREQ     = 100000000,
    parameter int SAMPLE_FREQ = 10000,
    parameter int CNT_W       = 16,
    parameter int NUM_CH      = 2,
    parameter int CH_W        = 1,
    parameter int DATA_W      = 12,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              enable,
    output logic              adc_start,
    output logic [CH_W-1:0]   adc_ch,
    input  logic              adc_done,
    input  logic [DATA_W-1:0] adc_data,
    output logic              sample_valid,
    output logic [CH_W-1:0]   sample_ch,
    output logic [DATA_W-1:0] sample_data,
    output logic              busy,
    output logic              overrun,
    output logic              timeout_err
);
    localparam int TICK_DIV = IN_FREQ / SAMPLE_FREQ;
    localparam int WAIT_W   = $clog2(TIMEOUT_CYC);

    localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NUM_CH - 1);

    if (TICK_DIV < 2) begin : g_bad_div
        $error("adc_sample_sequencer: TICK_DIV must be at least 2");
    end
    if (((TICK_DIV - 1) >> CNT_W) != 0) begin : g_bad_cnt
        $error("adc_sample_sequencer: TICK_DIV does not fit in CNT_W bits");
    end
    if (TIMEOUT_CYC < 2) begin : g_bad_to
        $error("adc_sample_sequencer: TIMEOUT_CYC must be at least 2");
    end
    if (NUM_CH < 1 || ((NUM_CH - 1) >> CH_W) != 0) begin : g_bad_ch
        $error("adc_sample_sequencer: NUM_CH out of range for CH_W");
    end

    typedef enum logic [1:0] {IDLE, START, WAIT, STORE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  tick_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CH_W-1:0]   ch;
    logic              tick;

    // Counter freezes (rather than clears) while disabled so the frame phase survives a pause.
    assign tick = enable && (tick_cnt == TICK_LAST);

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset)
            tick_cnt <= '0;
        else if (enable)
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ch          <= '0;
            wait_cnt    <= '0;
            sample_ch   <= '0;
            sample_data <= '0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            // Any tick outside IDLE is dropped, including the cycle STORE returns to IDLE.
            overrun     <= tick && (state != IDLE);
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick) begin
                        ch    <= '0;
                        state <= START;
                    end
                end
                START: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    // done takes priority over the timeout on the last allowed cycle
                    if (adc_done) begin
                        sample_data <= adc_data;
                        sample_ch   <= ch;
                        state       <= STORE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                STORE: begin
                    if (ch == CH_LAST) begin
                        state <= IDLE;
                    end else begin
                        ch    <= ch + 1'b1;
                        state <= START;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ch only moves on entry to START, so adc_ch stays put for the whole conversion.
    assign adc_start    = (state == START);
    assign adc_ch       = ch;
    assign sample_valid = (state == STORE);
    assign busy         = (state != IDLE);
endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Scoreboard bench: two sequencer lanes (timeout 16 and 128) with ADC models; a frame-level
// predictor queues expected pulses per kind and a monitor pops them as the DUT fires.
module tb_adc_sample_sequencer;
    localparam int IN_FREQ     = 1000;
    localparam int SAMPLE_FREQ = 10;
    localparam int TICK_DIV    = 100;
    localparam int CNT_W       = 16;
    localparam int NUM_CH      = 2;
    localparam int CH_W        = 1;
    localparam int DATA_W      = 12;
    localparam int TO0         = 16;
    localparam int TO1         = 128;

    typedef struct {
        int cyc;
        int ch;
        int data;
    } ev_t;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    function automatic void check(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endfunction

    logic rst [2];
    logic en  [2];
    int   off_a [2][NUM_CH];
    int   off_b [2][NUM_CH];
    int   dbase [2][NUM_CH];
    int   dmul  [2];

    // Sample word returned for a conversion started at cycle s on channel c.
    function automatic int adc_word(int g, int s, int c);
        return (dbase[g][c] + s * dmul[g]) & 'hFFF;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int TO = (g == 0) ? TO0 : TO1;

        logic              adc_start, adc_done, sample_valid, busy, overrun, timeout_err;
        logic [CH_W-1:0]   adc_ch, sample_ch;
        logic [DATA_W-1:0] adc_data, sample_data;

        ev_t q_start[$];
        ev_t q_valid[$];
        ev_t q_ovr[$];
        ev_t q_to[$];
        int  en_seen = 0;
        int  lo = -1;
        int  hi = -1;

        adc_sample_sequencer #(
            .IN_FREQ(IN_FREQ), .SAMPLE_FREQ(SAMPLE_FREQ), .CNT_W(CNT_W), .NUM_CH(NUM_CH),
            .CH_W(CH_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TO)
        ) dut (
            .clk_in(clk_in), .reset(rst[g]), .enable(en[g]),
            .adc_start(adc_start), .adc_ch(adc_ch), .adc_done(adc_done), .adc_data(adc_data),
            .sample_valid(sample_valid), .sample_ch(sample_ch), .sample_data(sample_data),
            .busy(busy), .overrun(overrun), .timeout_err(timeout_err)
        );

        // ADC model: each start schedules done pulse(s) at fixed offsets; data is garbage otherwise.
        int done_at [int];
        initial begin
            adc_done = 1'b0;
            adc_data = '0;
            forever begin
                int c;
                @(negedge clk_in);
                if (rst[g]) begin
                    done_at.delete();
                end else if (adc_start) begin
                    c = int'(adc_ch);
                    if (off_a[g][c] >= 0) done_at[cyc + off_a[g][c]] = adc_word(g, cyc, c);
                    if (off_b[g][c] >= 0) done_at[cyc + off_b[g][c]] = adc_word(g, cyc, c);
                end
                adc_done = done_at.exists(cyc);
                adc_data = adc_done ? DATA_W'(done_at[cyc]) : DATA_W'($urandom);
                if (adc_done) done_at.delete(cyc);
            end
        end

        // A frame started at s0 produces every pulse of that frame by plain arithmetic.
        task automatic plan_frame(int s0);
            int s;
            int d;
            s  = s0;
            lo = s0;
            for (int c = 0; c < NUM_CH; c++) begin
                d = -1;
                if (off_a[g][c] >= 1 && off_a[g][c] <= TO) d = off_a[g][c];
                if (off_b[g][c] >= 1 && off_b[g][c] <= TO && (d < 0 || off_b[g][c] < d)) d = off_b[g][c];
                q_start.push_back(ev_t'{s, c, 0});
                if (d < 0) begin
                    q_to.push_back(ev_t'{s + TO + 1, c, 0});
                    hi = s + TO;
                    return;
                end
                q_valid.push_back(ev_t'{s + d + 1, c, adc_word(g, s, c)});
                hi = s + d + 1;
                s  = s + d + 2;
            end
        endtask

        // Predictor: a tick falls on every TICK_DIV-th enabled cycle since reset.
        initial begin
            forever begin
                @(negedge clk_in);
                if (rst[g]) begin
                    en_seen = 0;
                    lo      = -1;
                    hi      = -1;
                    while (q_start.size() > 0 && q_start[$].cyc >= cyc) void'(q_start.pop_back());
                    while (q_valid.size() > 0 && q_valid[$].cyc >= cyc) void'(q_valid.pop_back());
                    while (q_ovr.size() > 0 && q_ovr[$].cyc >= cyc) void'(q_ovr.pop_back());
                    while (q_to.size() > 0 && q_to[$].cyc >= cyc) void'(q_to.pop_back());
                end else begin
                    if (en[g] && (en_seen % TICK_DIV == TICK_DIV - 1)) begin
                        if (cyc <= hi) q_ovr.push_back(ev_t'{cyc + 1, 0, 0});
                        else plan_frame(cyc + 1);
                    end
                    if (en[g]) en_seen++;
                end
            end
        end

        // Monitor
        initial begin
            forever begin
                ev_t e;
                @(negedge clk_in);
                if (rst[g]) begin
                    check($sformatf("lane%0d_reset_outputs", g),
                          int'({adc_start, adc_ch, sample_valid, sample_ch, sample_data,
                                busy, overrun, timeout_err}), 0);
                end else begin
                    while (q_start.size() > 0 && q_start[0].cyc < cyc) begin
                        e = q_start.pop_front();
                        check($sformatf("lane%0d_adc_start_missing", g), -1, e.cyc);
                    end
                    while (q_valid.size() > 0 && q_valid[0].cyc < cyc) begin
                        e = q_valid.pop_front();
                        check($sformatf("lane%0d_sample_valid_missing", g), -1, e.cyc);
                    end
                    while (q_ovr.size() > 0 && q_ovr[0].cyc < cyc) begin
                        e = q_ovr.pop_front();
                        check($sformatf("lane%0d_overrun_missing", g), -1, e.cyc);
                    end
                    while (q_to.size() > 0 && q_to[0].cyc < cyc) begin
                        e = q_to.pop_front();
                        check($sformatf("lane%0d_timeout_missing", g), -1, e.cyc);
                    end
                    if (adc_start) begin
                        if (q_start.size() == 0) check($sformatf("lane%0d_adc_start_unexpected", g), cyc, -1);
                        else begin
                            e = q_start.pop_front();
                            check($sformatf("lane%0d_adc_start_cycle", g), cyc, e.cyc);
                            check($sformatf("lane%0d_adc_ch", g), int'(adc_ch), e.ch);
                        end
                    end
                    if (sample_valid) begin
                        if (q_valid.size() == 0) check($sformatf("lane%0d_sample_valid_unexpected", g), cyc, -1);
                        else begin
                            e = q_valid.pop_front();
                            check($sformatf("lane%0d_sample_valid_cycle", g), cyc, e.cyc);
                            check($sformatf("lane%0d_sample_ch", g), int'(sample_ch), e.ch);
                            check($sformatf("lane%0d_sample_data", g), int'(sample_data), e.data);
                        end
                    end
                    if (overrun) begin
                        if (q_ovr.size() == 0) check($sformatf("lane%0d_overrun_unexpected", g), cyc, -1);
                        else begin
                            e = q_ovr.pop_front();
                            check($sformatf("lane%0d_overrun_cycle", g), cyc, e.cyc);
                        end
                    end
                    if (timeout_err) begin
                        if (q_to.size() == 0) check($sformatf("lane%0d_timeout_unexpected", g), cyc, -1);
                        else begin
                            e = q_to.pop_front();
                            check($sformatf("lane%0d_timeout_cycle", g), cyc, e.cyc);
                        end
                    end
                    check($sformatf("lane%0d_busy", g), int'(busy), int'(cyc >= lo && cyc <= hi));
                end
            end
        end
    end

    task automatic step(int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic cfg(int g, int a0, int a1, int b0, int b1, int d0, int d1, int mul);
        off_a[g][0] = a0; off_a[g][1] = a1;
        off_b[g][0] = b0; off_b[g][1] = b1;
        dbase[g][0] = d0; dbase[g][1] = d1;
        dmul[g]     = mul;
    endtask

    // Quiesce the lane, reset it, apply the new ADC behaviour, then enable.
    task automatic new_test(int g, int a0, int a1, int b0, int b1, int d0, int d1, int mul);
        en[g] = 1'b0;
        step(300);
        rst[g] = 1'b1;
        cfg(g, a0, a1, b0, b1, d0, d1, mul);
        step(3);
        rst[g] = 1'b0;
        en[g]  = 1'b1;
    endtask

    function automatic int rand_off(int to);
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return -1;
        if (r == 1) return 0;
        if (r == 2) return to + 1;
        return int'($urandom_range(1, to));
    endfunction

    initial begin
        for (int g = 0; g < 2; g++) begin
            rst[g] = 1'b1;
            en[g]  = 1'b0;
            cfg(g, -1, -1, -1, -1, 0, 0, 0);
        end

        // Nominal frames: done 3 cycles after start, fixed sample words.
        new_test(0, 3, 3, -1, -1, 'h123, 'hABC, 0);
        step(350);
        // ADC never answers: timeouts, no samples.
        new_test(0, -1, -1, -1, -1, 0, 0, 0);
        step(350);
        // done in START (ignored) and again on the timeout cycle (captured).
        new_test(0, 0, 0, TO0, TO0, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)), int'($urandom));
        step(350);
        // Reset while channel 1 is waiting.
        new_test(0, 3, 10, -1, -1, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)), int'($urandom));
        step(108);
        rst[0] = 1'b1;
        step(3);
        rst[0] = 1'b0;
        step(250);
        // enable dropped mid-frame for 500 cycles.
        new_test(0, 5, 5, -1, -1, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)), int'($urandom));
        step(102);
        en[0] = 1'b0;
        step(500);
        en[0] = 1'b1;
        step(300);
        // Slow ADC on the long-timeout lane: overrun during channel 1.
        new_test(1, 60, 60, -1, -1, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)), int'($urandom));
        step(450);

        for (int g = 0; g < 2; g++) begin
            for (int k = 0; k < 3; k++) begin
                new_test(g, rand_off(g ? TO1 : TO0), rand_off(g ? TO1 : TO0), -1, -1,
                         int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)), int'($urandom));
                step(int'($urandom_range(150, 250)));
                en[g] = 1'b0;
                step(int'($urandom_range(0, 200)));
                en[g] = 1'b1;
                step(400);
            end
        end

        en[0] = 1'b0;
        en[1] = 1'b0;
        step(300);
        check("lane0_leftover_events", lane[0].q_start.size() + lane[0].q_valid.size()
              + lane[0].q_ovr.size() + lane[0].q_to.size(), 0);
        check("lane1_leftover_events", lane[1].q_start.size() + lane[1].q_valid.size()
              + lane[1].q_ovr.size() + lane[1].q_to.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
